// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer plus counter-based debounce with rise/fall pulses
module key_debounce #(
    parameter int   G_SYNC_STAGES = 2,
    parameter int   G_DB_CNT      = 1000000,
    parameter int   G_CNT_WIDTH   = 20,
    parameter logic G_IDLE_LEVEL  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic signal,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    localparam logic [G_CNT_WIDTH-1:0] CNT_LAST = G_CNT_WIDTH'(G_DB_CNT - 1);
    localparam logic [G_CNT_WIDTH-1:0] CNT_ONE  = G_CNT_WIDTH'(1);

    logic [G_SYNC_STAGES-1:0] sync_q;
    logic                     s;
    state_t                   state;
    logic [G_CNT_WIDTH-1:0]   cnt;

    // Plain flop chain on the raw input; stage 0 is the only flop that can go metastable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {G_SYNC_STAGES{G_IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[G_SYNC_STAGES-2:0], signal};
        end
    end

    assign s = sync_q[G_SYNC_STAGES-1];

    // Qualify a candidate level: it must persist until the counter reaches its last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= STABLE;
            cnt     <= '0;
            o_level <= G_IDLE_LEVEL;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            case (state)
                STABLE: begin
                    cnt <= '0;
                    if (s != o_level) begin
                        state  <= CHECK;
                        o_busy <= 1'b1;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                CHECK: begin
                    if (s == o_level) begin
                        // Any return to the current level throws away the partial count
                        state  <= STABLE;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= STABLE;
                        cnt     <= '0;
                        o_busy  <= 1'b0;
                        o_level <= s;
                        o_rise  <= s;
                        o_fall  <= ~s;
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                        o_busy <= 1'b1;
                    end
                end
                default: begin
                    state  <= STABLE;
                    cnt    <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
